// File: rtl/mcycle_pkg.sv
// Shared constants for the multi-cycle multiply/divide unit.
package mcycle_pkg;
  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;
  localparam int   WIDTH  = 32;
  localparam int   ITERS  = 32;
  localparam int   CNT_W  = $clog2(ITERS);
endpackage

// File: rtl/mcycle_negate.sv
// 64-bit conditional two's-complement negator used for all sign fix-ups.
module mcycle_negate (
  input  logic        neg,
  input  logic [63:0] a,
  output logic [63:0] y
);
  assign y = neg ? (~a + 64'd1) : a;
endmodule

// File: rtl/mcycle.sv
// Iterative 32-bit multiply (shift-add) / divide (restoring) unit that stalls the pipeline.
//
// state     | meaning
// IDLE      | waiting for Start; latches operands on Start
// COMPUTING | one shift-add / shift-subtract iteration per cycle, 32 in total
// DONE      | results valid, Busy low, Start ignored for one cycle
module mcycle
  import mcycle_pkg::*;
(
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             Start,
  input  logic             MCycleOp,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy
);
  typedef enum logic [1:0] {IDLE, COMPUTING, DONE} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic             op_q, sgn_q, s1_q, s2_q;
  logic [63:0]      opa, acc, acc_nx, mag1, mag2, res_fix, rem_fix;
  logic [31:0]      opb, opb_nx;
  logic [32:0]      rem_sh, diff;
  logic             ge, last, div0, unused_hi;

  // Sign-extend only in signed mode so the negated value is a clean 64-bit magnitude.
  mcycle_negate u_mag1 (
    .neg (Signed & Operand1[31]),
    .a   ({{32{Signed & Operand1[31]}}, Operand1}),
    .y   (mag1)
  );
  mcycle_negate u_mag2 (
    .neg (Signed & Operand2[31]),
    .a   ({{32{Signed & Operand2[31]}}, Operand2}),
    .y   (mag2)
  );
  mcycle_negate u_res (
    .neg (sgn_q & (s1_q ^ s2_q)),
    .a   ((op_q == OP_MUL) ? acc_nx : {32'b0, opb_nx}),
    .y   (res_fix)
  );
  mcycle_negate u_rem (
    .neg (sgn_q & s1_q),
    .a   ({32'b0, acc_nx[31:0]}),
    .y   (rem_fix)
  );

  assign unused_hi = ^rem_fix[63:32];
  assign last      = (cnt == CNT_W'(ITERS - 1));
  assign div0      = (opa[31:0] == 32'd0);

  always_ff @(posedge CLK) begin
    if (!RESETn) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (Start) state_nx = COMPUTING;
      COMPUTING: if (last)  state_nx = DONE;
      DONE:      state_nx = IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    Busy = ((state == IDLE) && Start) || (state == COMPUTING);
  end

  // Divide keeps the partial remainder in acc[32:0] and shifts the dividend out of opb
  // while quotient bits shift in behind it.
  always_comb begin
    rem_sh = {acc[31:0], opb[31]};
    diff   = rem_sh - {1'b0, opa[31:0]};
    ge     = (rem_sh >= {1'b0, opa[31:0]});
    if (op_q == OP_MUL) begin
      acc_nx = opb[0] ? (acc + opa) : acc;
      opb_nx = opb >> 1;
    end else begin
      acc_nx = {31'b0, ge ? diff : rem_sh};
      opb_nx = {opb[30:0], ge};
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      cnt     <= '0;
      op_q    <= 1'b0;
      sgn_q   <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      opa     <= '0;
      opb     <= '0;
      acc     <= '0;
      Result1 <= '0;
      Result2 <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          op_q  <= MCycleOp;
          sgn_q <= Signed;
          s1_q  <= Operand1[31];
          s2_q  <= Operand2[31];
          cnt   <= '0;
          acc   <= '0;
          if (MCycleOp == OP_MUL) begin
            opa <= mag1;
            opb <= mag2[31:0];
          end else begin
            opa <= mag2;
            opb <= mag1[31:0];
          end
        end
        COMPUTING: begin
          acc <= acc_nx;
          opb <= opb_nx;
          cnt <= cnt + 1'b1;
          if (op_q == OP_MUL) opa <= opa << 1;
          if (last) begin
            // Divide by zero: the remainder fix-up already restores the original dividend.
            Result1 <= (op_q == OP_DIV && div0) ? '1 : res_fix[31:0];
            Result2 <= (op_q == OP_MUL) ? res_fix[63:32] : rem_fix[31:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mcycle.sv
// Scoreboard bench for mcycle: reference results queued at issue, compared in DONE.
module tb_mcycle;
  logic        CLK = 1'b0;
  logic        RESETn, Start, MCycleOp, Signed;
  logic [31:0] Operand1, Operand2, Result1, Result2;
  logic        Busy;

  int          n_run = 0;
  int          n_fail = 0;
  logic [63:0] sb_q[$];
  bit          held = 1'b0;

  always #5 CLK = ~CLK;

  mcycle dut (
    .CLK      (CLK),
    .RESETn   (RESETn),
    .Start    (Start),
    .MCycleOp (MCycleOp),
    .Signed   (Signed),
    .Operand1 (Operand1),
    .Operand2 (Operand2),
    .Result1  (Result1),
    .Result2  (Result2),
    .Busy     (Busy)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Returns {Result2, Result1}.
  function automatic logic [63:0] model(input logic op, input logic sgn,
                                        input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 1'b0)
      r = sgn ? 64'(sa * sb) : ({32'b0, a} * {32'b0, b});
    else if (b == 32'd0)
      r = {a, 32'hFFFF_FFFF};
    else if (sgn)
      r = {32'(sa % sb), 32'(sa / sb)};
    else
      r = {a % b, a / b};
    return r;
  endfunction

  task automatic run_op(input logic op, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input bit keep);
    int n;
    logic [63:0] exp;
    MCycleOp = op;
    Signed   = sgn;
    Operand1 = a;
    Operand2 = b;
    Start    = 1'b1;
    sb_q.push_back(model(op, sgn, a, b));
    #1;
    if (held) begin
      check("no_restart_in_done", 64'(Busy), 64'd0);
      @(negedge CLK);
    end
    n = 0;
    while (Busy && n < 100) begin
      n++;
      if (n == 5) begin
        Operand1 = $urandom;
        Operand2 = $urandom;
        MCycleOp = ~op;
        Signed   = ~sgn;
      end
      @(negedge CLK);
    end
    check("busy_cycles", 64'(n), 64'd33);
    check("busy_done", 64'(Busy), 64'd0);
    exp = sb_q.pop_front();
    check("result", {Result2, Result1}, exp);
    held = keep;
    if (!keep) begin
      Start = 1'b0;
      @(negedge CLK);
      check("result_hold", {Result2, Result1}, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    RESETn = 1'b0; Start = 1'b0; MCycleOp = 1'b0; Signed = 1'b0;
    Operand1 = '0; Operand2 = '0;
    repeat (3) @(negedge CLK);
    check("reset_result", {Result2, Result1}, 64'd0);
    check("reset_busy", 64'(Busy), 64'd0);
    Start = 1'b1;
    #1 check("reset_busy_eq_start", 64'(Busy), 64'd1);
    Start = 1'b0;
    @(negedge CLK);
    RESETn = 1'b1;
    @(negedge CLK);

    run_op(1'b0, 1'b0, 32'd7, 32'd6, 1'b0);
    run_op(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    run_op(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h10, 1'b0);
    run_op(1'b1, 1'b1, 32'd100, 32'd0, 1'b0);
    run_op(1'b1, 1'b0, 32'd100, 32'd0, 1'b0);
    run_op(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b1, 1'b1, 32'hFFFF_FF9C, 32'd0, 1'b0);
    run_op(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
    for (int i = 0; i < 6; i++)
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
             (i == 3) ? 32'd0 : $urandom, 1'b0);

    // Start held high across DONE: the second op must begin only in the following IDLE.
    run_op(1'b0, 1'b0, 32'd11, 32'd13, 1'b1);
    run_op(1'b1, 1'b0, 32'd1000, 32'd7, 1'b0);

    // Abort in the middle of COMPUTING.
    MCycleOp = 1'b0; Signed = 1'b0; Operand1 = 32'd123; Operand2 = 32'd456; Start = 1'b1;
    repeat (10) @(negedge CLK);
    RESETn = 1'b0;
    @(negedge CLK);
    check("abort_busy_eq_start", 64'(Busy), 64'(Start));
    check("abort_result", {Result2, Result1}, 64'd0);
    Start = 1'b0;
    #1 check("abort_busy_idle", 64'(Busy), 64'd0);
    RESETn = 1'b1;
    @(negedge CLK);
    run_op(1'b0, 1'b0, 32'd3, 32'd3, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
